pp_prefix_adder: RTL and testbench
==================================

// Module: pp_prefix_adder
// PURPOSE
//  Parametrised, pipelined Kogge-Stone prefix adder/subtractor with a valid/ready stream interface.
//  Next generation of the 16-bit per-bit propagate/generate stage. It fuses pg generation, a
//  log2(WIDTH)-level prefix carry tree and sum formation into one elastic pipeline.
//  Feeds the modular multiplier datapath: partial-sum accumulation and conditional modulus subtraction.
// PARAMETERS
//  WIDTH       16  operand width in bits; any value >= 2
//  PIPE_EVERY  2   prefix-tree levels per register stage; 1..LOG2W
//  (derived) LOG2W = $clog2(WIDTH); LAT = 2 + ceil(LOG2W / PIPE_EVERY); WIDTH=16, PIPE_EVERY=2 -> LAT = 4
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      adder accepts a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in; ignored when sub=1
//  sub        in   1      1: compute a - b (a + ~b + 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  sum        out  WIDTH  result, mod 2^WIDTH
//  cout       out  1      carry-out; in sub mode 1 = no borrow (a >= b, unsigned)
// BEHAVIOUR
//  - Reset (async assert, sync release): every stage valid bit = 0, out_valid = 0, sum = 0, cout = 0.
//    Data registers clear to 0. Reset mid-operation discards all in-flight beats; no output after release.
//  - Stage 0 (register): b' = sub ? ~b : b; c0 = sub ? 1 : cin. Per bit, g_i = a_i & b'_i and
//    p_i = a_i ^ b'_i. Register {p,g}, the original p and c0.
//  - Prefix levels k = 0..LOG2W-1 (span 2^k), dot operator:
//    (G,P)_i = (g_i | p_i & g_{i-2^k}, p_i & p_{i-2^k}).
//    For i < 2^k, pass through unchanged. Fold c0 in as bit -1 generate: g_-1 = c0, p_-1 = 0.
//  - Register after every PIPE_EVERY levels and after the last level, even if it is a partial group.
//  - Final stage (register): carry_i = G_{i-1:-1}, sum_i = p_i ^ carry_i, cout = G_{WIDTH-1:-1}.
//  - Latency: a beat accepted at edge t appears on out_valid/sum/cout after edge t+LAT-1,
//    i.e. it is visible in cycle t+LAT when out_ready is held 1.
//  - Handshake:
//    - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
//    - Single global advance enable: adv = !out_valid | out_ready.
//    - in_ready = adv, combinational. This path is accepted.
//    - On adv, every stage shifts one place (valid bits included); stage 0 loads in_valid.
//    - With !adv, all stages hold. sum/cout stay stable while out_valid & !out_ready.
//    - Full throughput: 1 beat/cycle with out_ready = 1. Bubbles propagate as valid = 0.
//    - in_valid must not depend on in_ready. Inputs are sampled only on transfer.
//  - Order: results leave in acceptance order. No drop, no duplicate.
//  - Width rules: all arithmetic is unsigned mod 2^WIDTH. No overflow flag; signed overflow is derived
//    externally from the MSBs and cout.
//  - Non-power-of-2 WIDTH: tree depth = $clog2(WIDTH); out-of-range span indices pass through.
// TESTING (WIDTH=16, PIPE_EVERY=2, out_ready=1 unless stated)
//  1 a=FFFF b=0001 cin=0 sub=0 -> sum=0000 cout=1, out_valid 4 cycles after accept;
//    a=1234 b=4321 cin=1 -> sum=5556 cout=0
//  2 sub=1: a=0005 b=0007 -> sum=FFFE cout=0; a=0007 b=0005 cin=1 (ignored) -> sum=0002 cout=1
//  3 Back-to-back, 1000 random beats with in_valid=1 -> one result per cycle after a 4-cycle fill,
//    matches reference model, in order
//  4 Backpressure: 3 beats in flight, out_ready=0 for 5 cycles -> in_ready=0, sum/cout frozen;
//    release -> beats emerge in order with no loss
//  5 Reset: assert rst_n=0 mid-stream for 1 cycle -> out_valid=0, sum=0000 immediately;
//    no stale result after release; next beat appears 4 cycles after accept
//  6 Sweep WIDTH in {5,16,64} and PIPE_EVERY in {1,3} -> LAT matches the formula
//    (e.g. 64/1 -> 8); all-ones + cin=1 -> sum=0, cout=1

Source files
------------

// File: rtl/pp_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream.
// pg stage, registered prefix-tree groups, then a sum/carry-out stage.
`timescale 1ns/1ps
module pp_prefix_adder #(
    parameter int WIDTH      = 16,
    parameter int PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int LOG2W = $clog2(WIDTH);
    localparam int NSTG  = (LOG2W + PIPE_EVERY - 1) / PIPE_EVERY;

    // Position 0 of every pg vector is the carry-in (bit -1); bit i sits at i+1.
    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [WIDTH:0]   g0;
    logic [WIDTH:0]   p0;
    logic             sv [0:NSTG];
    logic [WIDTH:0]   sg [0:NSTG];
    logic [WIDTH:0]   sp [0:NSTG];
    logic [WIDTH-1:0] so [0:NSTG];
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign bx = sub ? ~b : b;
    assign c0 = sub | cin;
    assign g0 = {a & bx, c0};
    assign p0 = {a ^ bx, 1'b0};

    // Stage 0: capture per-bit generate/propagate on an input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv[0] <= 1'b0;
            sg[0] <= '0;
            sp[0] <= '0;
            so[0] <= '0;
        end else if (adv) begin
            sv[0] <= in_valid;
            if (in_valid) begin
                sg[0] <= g0;
                sp[0] <= p0;
                so[0] <= a ^ bx;
            end
        end
    end

    for (genvar k = 0; k < LOG2W; k++) begin : lv
        localparam int SPAN = 1 << k;
        logic [WIDTH:0] gi;
        logic [WIDTH:0] pi;
        logic [WIDTH:0] go;
        logic [WIDTH:0] po;
        if (k % PIPE_EVERY == 0) begin : g_reg
            assign gi = sg[k / PIPE_EVERY];
            assign pi = sp[k / PIPE_EVERY];
        end else begin : g_chain
            assign gi = lv[k-1].go;
            assign pi = lv[k-1].po;
        end
        for (genvar j = 0; j <= WIDTH; j++) begin : bt
            if (j >= SPAN) begin : g_dot
                assign go[j] = gi[j] | (pi[j] & gi[j-SPAN]);
                assign po[j] = pi[j] & pi[j-SPAN];
            end else begin : g_pass
                assign go[j] = gi[j];
                assign po[j] = pi[j];
            end
        end
    end

    for (genvar r = 1; r <= NSTG; r++) begin : st
        localparam int END = (r * PIPE_EVERY < LOG2W) ? r * PIPE_EVERY : LOG2W;
        localparam int LV  = END - 1;
        // Register the result of one group of prefix levels
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sv[r] <= 1'b0;
                sg[r] <= '0;
                sp[r] <= '0;
                so[r] <= '0;
            end else if (adv) begin
                sv[r] <= sv[r-1];
                if (sv[r-1]) begin
                    sg[r] <= lv[LV].go;
                    sp[r] <= lv[LV].po;
                    so[r] <= so[r-1];
                end
            end
        end
    end

    // With the carry-in as an extra position the top group can fall one
    // span short of it; its propagate then still reaches down to c0.
    assign sum_d  = so[NSTG] ^ sg[NSTG][WIDTH-1:0];
    assign cout_d = sg[NSTG][WIDTH] | (sp[NSTG][WIDTH] & sg[NSTG][0]);

    // Output stage: sum and carry-out, held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (adv) begin
            out_valid <= sv[NSTG];
            if (sv[NSTG]) begin
                sum  <= sum_d;
                cout <= cout_d;
            end
        end
    end
endmodule

// File: tb/tb_pp_prefix_adder.sv
// Directed bench for pp_prefix_adder: arithmetic, latency, streaming,
// backpressure, mid-stream reset and a width/pipelining sweep.
`timescale 1ns/1ps
module tb_pp_prefix_adder;
    localparam int W   = 16;
    localparam int LAT = 4;
    localparam int NX  = 6;

    function automatic int xw(input int i);
        case (i)
            0, 1:    return 5;
            2, 3:    return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int xp(input int i);
        return (i % 2 == 0) ? 1 : 3;
    endfunction

    function automatic int xl(input int i);
        case (i)
            0:       return 5;
            1:       return 3;
            2:       return 6;
            3:       return 4;
            4:       return 8;
            default: return 4;
        endcase
    endfunction

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    logic          x_iv;
    logic [63:0]   x_a;
    logic [63:0]   x_b;
    logic          x_cin;
    logic          x_sub;
    logic [NX-1:0] x_ir;
    logic [NX-1:0] x_ov;
    logic [NX-1:0] x_co;
    logic [NX-1:0] x_sz;

    int nvec = 0;
    int nerr = 0;

    pp_prefix_adder #(.WIDTH(W), .PIPE_EVERY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    for (genvar gi = 0; gi < NX; gi++) begin : g_sw
        localparam int XW = xw(gi);
        localparam int XP = xp(gi);
        logic [XW-1:0] s;
        pp_prefix_adder #(.WIDTH(XW), .PIPE_EVERY(XP)) u (
            .clk(clk), .rst_n(rst_n),
            .in_valid(x_iv), .in_ready(x_ir[gi]),
            .a(x_a[XW-1:0]), .b(x_b[XW-1:0]), .cin(x_cin), .sub(x_sub),
            .out_valid(x_ov[gi]), .out_ready(1'b1),
            .sum(s), .cout(x_co[gi])
        );
        assign x_sz[gi] = (s == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
        logic [W:0] r;
        if (sb) r = {(x >= y), x - y};
        else    r = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        return r;
    endfunction

    task automatic run_beat(input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ic, input logic is, output int lat,
                            output logic [W-1:0] s, output logic c);
        @(negedge clk);
        in_valid = 1'b1; a = ia; b = ib; cin = ic; sub = is; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = sum;
        c = cout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        x_iv = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL reset out_valid got %b want 0", out_valid);
        end
        nvec++;
        if (sum !== 16'h0000) begin
            nerr++; $display("FAIL reset sum got %h want 0000", sum);
        end
        nvec++;
        if (cout !== 1'b0) begin
            nerr++; $display("FAIL reset cout got %b want 0", cout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL reset in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [W-1:0] s;
        logic c;
        run_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, c);
        nvec++;
        if (lat !== LAT) begin
            nerr++; $display("FAIL add1 latency got %0d want %0d", lat, LAT);
        end
        nvec++;
        if ({c, s} !== 17'h10000) begin
            nerr++; $display("FAIL add1 cout/sum got %b/%h want 1/0000", c, s);
        end
        run_beat(16'h1234, 16'h4321, 1'b1, 1'b0, lat, s, c);
        nvec++;
        if ({c, s} !== 17'h05556) begin
            nerr++; $display("FAIL add2 cout/sum got %b/%h want 0/5556", c, s);
        end
    endtask

    task automatic test_sub();
        int lat;
        logic [W-1:0] s;
        logic c;
        run_beat(16'h0005, 16'h0007, 1'b0, 1'b1, lat, s, c);
        nvec++;
        if ({c, s} !== 17'h0FFFE) begin
            nerr++; $display("FAIL sub1 cout/sum got %b/%h want 0/fffe", c, s);
        end
        run_beat(16'h0007, 16'h0005, 1'b1, 1'b1, lat, s, c);
        nvec++;
        if ({c, s} !== 17'h10002) begin
            nerr++; $display("FAIL sub2 cout/sum got %b/%h want 1/0002", c, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] e;
        int first = -1;
        int last = -1;
        int got = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 1012; n++) begin
            @(negedge clk);
            if (n < 1000) begin
                in_valid = 1'b1;
                a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (first < 0) first = n;
                last = n;
                got++;
                nvec++;
                if (q.size() == 0) begin
                    nerr++; $display("FAIL b2b unexpected result %b/%h", cout, sum);
                end else begin
                    e = q.pop_front();
                    if ({cout, sum} !== e) begin
                        nerr++;
                        $display("FAIL b2b beat %0d got %h want %h", got - 1, {cout, sum}, e);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
        nvec++;
        if (first !== LAT) begin
            nerr++; $display("FAIL b2b fill got %0d want %0d", first, LAT);
        end
        nvec++;
        if (got !== 1000) begin
            nerr++; $display("FAIL b2b count got %0d want 1000", got);
        end
        nvec++;
        if (last - first !== 999) begin
            nerr++; $display("FAIL b2b span got %0d want 999", last - first);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] va [4] = '{16'h0101, 16'h8000, 16'hFFFF, 16'h7FFF};
        logic [W-1:0] vb [4] = '{16'h0202, 16'h8000, 16'h0001, 16'h0001};
        logic         vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W:0]   ev [4] = '{17'h00303, 17'h10000, 17'h1FFFE, 17'h08001};
        int k = 0;
        bit sent = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = va[3]; b = vb[3]; cin = vc[3]; sub = vs[3];
            #1;
            nvec++;
            if (in_ready !== 1'b0) begin
                nerr++; $display("FAIL bp in_ready cyc %0d got %b want 0", i, in_ready);
            end
            nvec++;
            if (out_valid !== 1'b1) begin
                nerr++; $display("FAIL bp out_valid cyc %0d got %b want 1", i, out_valid);
            end
            nvec++;
            if ({cout, sum} !== ev[0]) begin
                nerr++; $display("FAIL bp hold cyc %0d got %h want %h", i, {cout, sum}, ev[0]);
            end
        end
        for (int n = 0; n < 20 && k < 4; n++) begin
            @(negedge clk);
            if (sent) in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) sent = 1;
            if (out_valid) begin
                nvec++;
                if ({cout, sum} !== ev[k]) begin
                    nerr++; $display("FAIL bp order beat %0d got %h want %h", k, {cout, sum}, ev[k]);
                end
                k++;
            end
        end
        in_valid = 1'b0;
        nvec++;
        if (k !== 4) begin
            nerr++; $display("FAIL bp count got %0d want 4", k);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int stale = 0;
        logic [W-1:0] s;
        logic c;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'h1000 + W'(i); b = 16'h0100; cin = 1'b0; sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nvec++;
        if ({out_valid, sum} !== {1'b1, 16'h1102}) begin
            nerr++; $display("FAIL rstmid pre got %b/%h want 1/1102", out_valid, sum);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL rstmid out_valid got %b want 0", out_valid);
        end
        nvec++;
        if ({cout, sum} !== 17'h00000) begin
            nerr++; $display("FAIL rstmid cout/sum got %b/%h want 0/0000", cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        nvec++;
        if (stale !== 0) begin
            nerr++; $display("FAIL rstmid stale got %0d want 0", stale);
        end
        run_beat(16'h00FF, 16'h0F01, 1'b1, 1'b0, lat, s, c);
        nvec++;
        if (lat !== LAT) begin
            nerr++; $display("FAIL rstmid latency got %0d want %0d", lat, LAT);
        end
        nvec++;
        if ({c, s} !== 17'h01001) begin
            nerr++; $display("FAIL rstmid cout/sum got %b/%h want 0/1001", c, s);
        end
    endtask

    task automatic test_sweep();
        int   lat [NX];
        logic sz  [NX];
        logic co  [NX];
        for (int i = 0; i < NX; i++) begin
            lat[i] = 0; sz[i] = 1'b0; co[i] = 1'b0;
        end
        @(negedge clk);
        x_a = '1; x_b = '0; x_cin = 1'b1; x_sub = 1'b0; x_iv = 1'b1;
        #1;
        nvec++;
        if (x_ir !== '1) begin
            nerr++; $display("FAIL sweep in_ready got %b want 111111", x_ir);
        end
        @(negedge clk);
        x_iv = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            for (int i = 0; i < NX; i++) begin
                if (x_ov[i] && lat[i] == 0) begin
                    lat[i] = n; sz[i] = x_sz[i]; co[i] = x_co[i];
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < NX; i++) begin
            nvec++;
            if (lat[i] !== xl(i)) begin
                nerr++; $display("FAIL sweep w%0d/p%0d latency got %0d want %0d", xw(i), xp(i), lat[i], xl(i));
            end
            nvec++;
            if (sz[i] !== 1'b1) begin
                nerr++; $display("FAIL sweep w%0d/p%0d sum-zero got %b want 1", xw(i), xp(i), sz[i]);
            end
            nvec++;
            if (co[i] !== 1'b1) begin
                nerr++; $display("FAIL sweep w%0d/p%0d cout got %b want 1", xw(i), xp(i), co[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
